// File: rtl/game_sequencer.sv
//------------------------------------------------------------------------------
// game_sequencer
//
// Top-level game flow controller for the VGA brick-breaker. It runs on the
// 100 MHz ClkPort domain and walks the game through IDLE, SERVE, PLAY, MISS,
// WIN and OVER. It also produces the per-frame movement enable for the
// ball/paddle datapath, and it owns the BCD score and the lives count.
//
// Ports:
//   ClkPort        in   1   100 MHz system clock
//   Reset          in   1   asynchronous, active-high reset
//   vSync          in   1   active-low vertical sync (display clock domain)
//   btn_start      in   1   raw start button, asynchronous
//   brick_hit      in   1   one-cycle pulse, a brick was destroyed
//   ball_missed    in   1   one-cycle pulse, the ball passed the paddle
//   bricks_cleared in   1   level, no bricks remain
//   state          out  3   current state (IDLE=0 .. OVER=5)
//   move_en        out  1   one-cycle pulse that advances motion
//   ball_reset     out  1   level, holds the ball at the serve position
//   score          out 16   four-digit BCD score, digit3 in [15:12]
//   lives          out  2   remaining lives
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module game_sequencer #(
    parameter int LIVES_INIT      = 3,
    parameter int FRAMES_PER_MOVE = 2,
    parameter int SERVE_FRAMES    = 60,
    parameter int HOLD_FRAMES     = 120
) (
    input  logic        ClkPort,
    input  logic        Reset,
    input  logic        vSync,
    input  logic        btn_start,
    input  logic        brick_hit,
    input  logic        ball_missed,
    input  logic        bricks_cleared,
    output logic [2:0]  state,
    output logic        move_en,
    output logic        ball_reset,
    output logic [15:0] score,
    output logic [1:0]  lives
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SERVE = 3'd1;
    localparam logic [2:0] ST_PLAY  = 3'd2;
    localparam logic [2:0] ST_MISS  = 3'd3;
    localparam logic [2:0] ST_WIN   = 3'd4;
    localparam logic [2:0] ST_OVER  = 3'd5;

    localparam logic [1:0] LIVES_INIT_C = 2'(LIVES_INIT);
    localparam logic [7:0] SERVE_LAST_C = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST_C  = 8'(HOLD_FRAMES - 1);
    localparam logic [3:0] MOVE_LAST_C  = 4'(FRAMES_PER_MOVE - 1);

    // BCD increment with per-digit carry; 9999 saturates rather than wrapping.
    function automatic logic [15:0] bcd_inc(input logic [15:0] val);
        logic [15:0] res;
        logic        carry;
        res   = val;
        carry = 1'b1;
        if (val == 16'h9999) begin
            res = val;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (res[i*4 +: 4] == 4'd9) begin
                        res[i*4 +: 4] = 4'd0;
                    end else begin
                        res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end else begin
                    res = res;
                end
            end
        end
        return res;
    endfunction

    // Input conditioning registers
    logic start_meta_q, start_sync_q, start_prev_q, start_pulse_q;
    logic vs_meta_q, vs_sync_q, vs_prev_q, frame_tick_q;
    logic start_pulse_d, frame_tick_d;

    // Game state registers and their next-state values
    logic [2:0]  state_q, state_d;
    logic [15:0] score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  move_div_q, move_div_d;
    logic        move_en_q, move_en_d;
    logic        ball_reset_q, ball_reset_d;

    // Edge detectors on the synchronized inputs. Each pulse is registered, so
    // a vSync fall shows up as frame_tick three clocks later.
    always_comb begin
        start_pulse_d = start_sync_q & ~start_prev_q;
        frame_tick_d  = vs_prev_q & ~vs_sync_q;
    end

    // Two-flop synchronizers, previous-value flops and registered edge pulses.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            start_meta_q  <= 1'b0;
            start_sync_q  <= 1'b0;
            start_prev_q  <= 1'b0;
            start_pulse_q <= 1'b0;
            vs_meta_q     <= 1'b0;
            vs_sync_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            frame_tick_q  <= 1'b0;
        end else begin
            start_meta_q  <= btn_start;
            start_sync_q  <= start_meta_q;
            start_prev_q  <= start_sync_q;
            start_pulse_q <= start_pulse_d;
            vs_meta_q     <= vSync;
            vs_sync_q     <= vs_meta_q;
            vs_prev_q     <= vs_sync_q;
            frame_tick_q  <= frame_tick_d;
        end
    end

    // Game flow next-state logic: phase transitions, score/lives and the move divider.
    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        lives_d     = lives_q;
        frame_cnt_d = frame_cnt_q;
        move_div_d  = 4'd0;
        move_en_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                frame_cnt_d = 8'd0;
                if (start_pulse_q) begin
                    state_d = ST_SERVE;
                    score_d = 16'h0000;
                    lives_d = LIVES_INIT_C;
                end else begin
                    state_d = state_q;
                end
            end

            ST_SERVE: begin
                if (frame_tick_q) begin
                    if (frame_cnt_q >= SERVE_LAST_C) begin
                        state_d     = ST_PLAY;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end

            ST_PLAY: begin
                frame_cnt_d = 8'd0;
                // The score update is independent of which transition wins.
                if (brick_hit) begin
                    score_d = bcd_inc(score_q);
                end else begin
                    score_d = score_q;
                end
                if (ball_missed) begin
                    lives_d = (lives_q == 2'd0) ? 2'd0 : (lives_q - 2'd1);
                    state_d = (lives_q <= 2'd1) ? ST_OVER : ST_MISS;
                end else if (bricks_cleared) begin
                    state_d = ST_WIN;
                end else begin
                    // The divider runs only while play continues, so move_en
                    // never fires on the cycle PLAY is left.
                    if (frame_tick_q) begin
                        if (move_div_q >= MOVE_LAST_C) begin
                            move_div_d = 4'd0;
                            move_en_d  = 1'b1;
                        end else begin
                            move_div_d = move_div_q + 4'd1;
                        end
                    end else begin
                        move_div_d = move_div_q;
                    end
                end
            end

            ST_MISS, ST_WIN: begin
                if (frame_tick_q) begin
                    if (frame_cnt_q >= HOLD_LAST_C) begin
                        state_d     = ST_SERVE;
                        frame_cnt_d = 8'd0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end else begin
                    frame_cnt_d = frame_cnt_q;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                frame_cnt_d = 8'd0;
            end
        endcase

        ball_reset_d = (state_d != ST_PLAY);
    end

    // Game state and output registers.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            score_q      <= 16'h0000;
            lives_q      <= LIVES_INIT_C;
            frame_cnt_q  <= 8'd0;
            move_div_q   <= 4'd0;
            move_en_q    <= 1'b0;
            ball_reset_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            frame_cnt_q  <= frame_cnt_d;
            move_div_q   <= move_div_d;
            move_en_q    <= move_en_d;
            ball_reset_q <= ball_reset_d;
        end
    end

    assign state      = state_q;
    assign move_en    = move_en_q;
    assign ball_reset = ball_reset_q;
    assign score      = score_q;
    assign lives      = lives_q;

endmodule
